// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction memory read port, queue write side and back-end redirect.
// The master modport belongs to inst_fetch and the slave modport to the memory/queue/back-end environment.
interface inst_fetch_if;
   logic [31:0] imem_address;
   logic        imem_read;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        inst_q_full;
   logic        fetch_enq;
   logic [31:0] fetch_inst;
   logic [31:0] fetch_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_address, imem_read, fetch_enq, fetch_inst, fetch_pc,
      input  imem_rdata, imem_resp, inst_q_full, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_address, imem_read, fetch_enq, fetch_inst, fetch_pc,
      output imem_rdata, imem_resp, inst_q_full, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch front end: single-outstanding imem reads, one-entry hold buffer, PC redirect.
// Optional JAL_PREDICT_EN: follow direct JAL targets at enqueue instead of pc+4.
//
//  state | meaning
//  REQ   | read outstanding at pc; enqueue on response if queue has room
//  HOLD  | response parked in hold buffer waiting for queue space; no read
//  DRAIN | wrong-path read still in flight; discard it, then restart at pend_pc
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic          clk,
   input  logic          rst,
   inst_fetch_if.master  fe_io
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] last_inst_q, last_pc_q;

   logic        rd;
   logic        enq;
   logic [31:0] enq_inst;
   logic [31:0] enq_pc;
   logic [31:0] next_pc;
   logic [31:0] redir_pc;

   assign redir_pc = fe_io.redirect_pc & 32'hFFFF_FFFC;

   // The word being enqueued comes from the hold buffer in HOLD, else straight from memory.
   always_comb begin
      enq_inst = fe_io.imem_rdata;
      enq_pc   = pc_q;
      if (state_q == S_HOLD) begin
         enq_inst = hold_q;
         enq_pc   = hold_pc_q;
      end
   end

`ifdef JAL_PREDICT_EN
   logic [31:0] jal_off;
   assign jal_off = {{11{enq_inst[31]}}, enq_inst[31], enq_inst[19:12],
                     enq_inst[20], enq_inst[30:21], 1'b0};
   assign next_pc = (enq_inst[6:0] == 7'b1101111) ? (enq_pc + jal_off) : (enq_pc + 32'd4);
`else
   assign next_pc = enq_pc + 32'd4;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      hold_d    = hold_q;
      hold_pc_d = hold_pc_q;
      rd        = 1'b0;
      enq       = 1'b0;
      case (state_q)
         S_REQ: begin
            rd = 1'b1;
            if (fe_io.redirect_valid) begin
               if (fe_io.imem_resp) begin
                  pc_d = redir_pc;
               end else begin
                  pend_pc_d = redir_pc;
                  state_d   = S_DRAIN;
               end
            end else if (fe_io.imem_resp) begin
               if (!fe_io.inst_q_full) begin
                  enq  = 1'b1;
                  pc_d = next_pc;
               end else begin
                  hold_d    = fe_io.imem_rdata;
                  hold_pc_d = pc_q;
                  state_d   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (fe_io.redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_REQ;
            end else if (!fe_io.inst_q_full) begin
               enq     = 1'b1;
               pc_d    = next_pc;
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            rd = 1'b1;
            if (fe_io.redirect_valid) begin
               pend_pc_d = redir_pc;
            end
            if (fe_io.imem_resp) begin
               pc_d    = fe_io.redirect_valid ? redir_pc : pend_pc_q;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         pend_pc_q   <= RESET_PC;
         hold_q      <= 32'd0;
         hold_pc_q   <= RESET_PC;
         last_inst_q <= 32'd0;
         last_pc_q   <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         hold_q    <= hold_d;
         hold_pc_q <= hold_pc_d;
         if (enq) begin
            last_inst_q <= enq_inst;
            last_pc_q   <= enq_pc;
         end
      end
   end

   // Read is gated by rst so the request only appears once reset has been released.
   assign fe_io.imem_read    = rd & ~rst;
   assign fe_io.imem_address = pc_q;
   assign fe_io.fetch_enq    = enq;
   assign fe_io.fetch_inst   = enq ? enq_inst : last_inst_q;
   assign fe_io.fetch_pc     = enq ? enq_pc : last_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, queue back-pressure, redirects, wrap, JAL, reset.
module tb_inst_fetch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch dut (
      .clk   (clk),
      .rst   (rst),
      .fe_io (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic resp, input logic [31:0] rdata, input logic full,
                        input logic rv, input logic [31:0] rpc);
      bus.imem_resp      = resp;
      bus.imem_rdata     = rdata;
      bus.inst_q_full    = full;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
   endtask

   task automatic idle();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      #2;
      check("rst_read", {31'd0, bus.imem_read}, 32'd0);
      check("rst_addr", bus.imem_address, 32'h60);
      check("rst_enq",  {31'd0, bus.fetch_enq}, 32'd0);
      check("rst_inst", bus.fetch_inst, 32'd0);
      check("rst_pc",   bus.fetch_pc, 32'h60);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One read at addr: a cycle with no response, then a response with the queue open.
   task automatic serve(input logic [31:0] addr);
      idle();
      #3;
      check("srv_read", {31'd0, bus.imem_read}, 32'd1);
      check("srv_addr", bus.imem_address, addr);
      check("srv_noenq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      drive(1'b1, word(addr), 1'b0, 1'b0, 32'd0);
      #3;
      check("srv_addr2", bus.imem_address, addr);
      check("srv_enq",  {31'd0, bus.fetch_enq}, 32'd1);
      check("srv_pc",   bus.fetch_pc, addr);
      check("srv_inst", bus.fetch_inst, word(addr));
      tick();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();

      // Sequential fetch from RESET_PC
      do_reset();
      serve(32'h60);
      serve(32'h64);
      serve(32'h68);

      // Queue full on the 0x64 response, held for five cycles
      do_reset();
      serve(32'h60);
      idle();
      #3;
      check("bp_addr", bus.imem_address, 32'h64);
      tick();
      drive(1'b1, word(32'h64), 1'b1, 1'b0, 32'd0);
      #3;
      check("bp_noenq_resp", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
         #3;
         check("bp_hold_read", {31'd0, bus.imem_read}, 32'd0);
         check("bp_hold_enq",  {31'd0, bus.fetch_enq}, 32'd0);
         tick();
      end
      idle();
      #3;
      check("bp_rel_read", {31'd0, bus.imem_read}, 32'd0);
      check("bp_rel_enq",  {31'd0, bus.fetch_enq}, 32'd1);
      check("bp_rel_pc",   bus.fetch_pc, 32'h64);
      check("bp_rel_inst", bus.fetch_inst, word(32'h64));
      tick();
      serve(32'h68);

      // Redirect while 0x70 is outstanding
      serve(32'h6C);
      drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h200);
      #3;
      check("dr_redir_enq",  {31'd0, bus.fetch_enq}, 32'd0);
      check("dr_redir_addr", bus.imem_address, 32'h70);
      tick();
      for (int i = 0; i < 2; i++) begin
         idle();
         #3;
         check("dr_wait_read", {31'd0, bus.imem_read}, 32'd1);
         check("dr_wait_addr", bus.imem_address, 32'h70);
         tick();
      end
      drive(1'b1, word(32'h70), 1'b0, 1'b0, 32'd0);
      #3;
      check("dr_resp_noenq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      serve(32'h200);

      // Redirect coinciding with a response; low bits of the target dropped
      drive(1'b1, word(32'h204), 1'b0, 1'b1, 32'h103);
      #3;
      check("rr_noenq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      serve(32'h100);

      // Wrap from 0xFFFF_FFFC to 0
      drive(1'b1, word(32'h104), 1'b0, 1'b1, 32'hFFFF_FFFC);
      #3;
      check("wr_noenq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      serve(32'hFFFF_FFFC);
      serve(32'h0);

      // Second redirect during DRAIN replaces the pending target
      drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h300);
      #3;
      check("ow_addr0", bus.imem_address, 32'h4);
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h400);
      #3;
      check("ow_addr1", bus.imem_address, 32'h4);
      check("ow_noenq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      drive(1'b1, word(32'h4), 1'b0, 1'b0, 32'd0);
      #3;
      check("ow_resp_noenq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      serve(32'h400);

      // JAL at RESET_PC, then reset while draining
      do_reset();
      idle();
      #3;
      check("jal_addr", bus.imem_address, 32'h60);
      tick();
      drive(1'b1, 32'h0100_006F, 1'b0, 1'b0, 32'd0);
      #3;
      check("jal_enq",  {31'd0, bus.fetch_enq}, 32'd1);
      check("jal_pc",   bus.fetch_pc, 32'h60);
      check("jal_inst", bus.fetch_inst, 32'h0100_006F);
      tick();
      idle();
      #3;
`ifdef JAL_PREDICT_EN
      check("jal_next", bus.imem_address, 32'h70);
`else
      check("jal_next", bus.imem_address, 32'h64);
`endif
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h500);
      #3;
      check("rd_redir_enq", {31'd0, bus.fetch_enq}, 32'd0);
      tick();
      idle();
      #2;
      rst = 1'b1;
      #1;
      check("rd_rst_read", {31'd0, bus.imem_read}, 32'd0);
      check("rd_rst_addr", bus.imem_address, 32'h60);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      check("rd_post_read", {31'd0, bus.imem_read}, 32'd1);
      check("rd_post_addr", bus.imem_address, 32'h60);
      tick();
      drive(1'b1, word(32'h60), 1'b0, 1'b0, 32'd0);
      #3;
      check("rd_post_enq", {31'd0, bus.fetch_enq}, 32'd1);
      check("rd_post_pc",  bus.fetch_pc, 32'h60);
      tick();
      idle();
      #3;
      check("rd_post_next", bus.imem_address, 32'h64);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
